// File: rtl/lpc_record_framer_pkg.sv
// Shared constants for the LPC record framer: frame sync byte, filter modes and FSM states.
package lpc_record_framer_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  localparam logic [1:0] FM_ALL  = 2'b00;
  localparam logic [1:0] FM_INCL = 2'b01;
  localparam logic [1:0] FM_EXCL = 2'b10;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE = 3'd0;
  localparam state_t ST_POP  = 3'd1;
  localparam state_t ST_WAIT = 3'd2;
  localparam state_t ST_EVAL = 3'd3;
  localparam state_t ST_SYNC = 3'd4;
  localparam state_t ST_BYTE = 3'd5;
  localparam state_t ST_CSUM = 3'd6;

  // Mode 2'b11 behaves as pass-all so a stray setting never silently drops traffic.
  function automatic logic filter_pass(input logic [1:0] mode, input logic hit);
    case (mode)
      FM_ALL:  return 1'b1;
      FM_INCL: return hit;
      FM_EXCL: return !hit;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lpc_record_framer_if.sv
// Ringbuffer-side pop handshake and uart_tx byte handshake seen by the framer.
interface lpc_record_framer_if #(
  parameter int DW = 48
);

  logic          read_empty;
  logic          read_clock_enable;
  logic [DW-1:0] read_data;
  logic          uart_ready;
  logic          uart_clock_enable;
  logic [7:0]    uart_data;

  modport master (
    input  read_empty,
    input  read_data,
    input  uart_ready,
    output read_clock_enable,
    output uart_clock_enable,
    output uart_data
  );

  modport slave (
    output read_empty,
    output read_data,
    output uart_ready,
    input  read_clock_enable,
    input  uart_clock_enable,
    input  uart_data
  );

endinterface

// File: rtl/lpc_record_framer_match.sv
// One match channel: masked equality compare of a record against a programmed value.
module record_match #(
  parameter int DW = 48
) (
  input  logic [DW-1:0] data_i,
  input  logic [DW-1:0] value_i,
  input  logic [DW-1:0] mask_i,
  output logic          hit_o
);

  // An all-zero mask disables the channel instead of matching everything.
  assign hit_o = (|mask_i) && (((data_i ^ value_i) & mask_i) == '0);

endmodule

// File: rtl/lpc_record_framer.sv
// Pops sniffer records, filters them through NCH match channels and sends passed records
// to the UART as SYNC + payload (MSB first) + XOR checksum.
module lpc_record_framer
  import lpc_record_framer_pkg::*;
#(
  parameter int         DW   = 48,
  parameter int         NCH  = 2,
  parameter logic [7:0] SYNC = SYNC_BYTE,
  parameter int         CW   = 16
) (
  input  logic                clock,
  input  logic                reset,
  lpc_record_framer_if.master bus,
  input  logic [1:0]          filter_mode_i,
  input  logic [NCH*DW-1:0]   match_value_i,
  input  logic [NCH*DW-1:0]   match_mask_i,
  output logic                match_hit_o,
  output logic [CW-1:0]       filtered_count_o,
  output logic [CW-1:0]       frame_count_o
);

  localparam int              NB       = DW / 8;
  localparam int              IW       = $clog2(NB);
  localparam logic [IW-1:0]   LAST_IDX = IW'(NB - 1);

  logic [NCH-1:0] chanHit;
  logic           anyHit;
  logic           recPass;
  logic           sending;
  logic           txFire;
  logic [7:0]     payloadByte;
  logic [7:0]     txByte;

  state_t         state_q,    state_d;
  logic [DW-1:0]  rec_q,      rec_d;
  logic [IW-1:0]  idx_q,      idx_d;
  logic [7:0]     csum_q,     csum_d;
  logic           block_q;
  logic [CW-1:0]  filtered_q, filtered_d;
  logic [CW-1:0]  frames_q,   frames_d;

  for (genvar c = 0; c < NCH; c++) begin : g_match
    record_match #(.DW(DW)) u_match (
      .data_i  (bus.read_data),
      .value_i (match_value_i[c*DW +: DW]),
      .mask_i  (match_mask_i[c*DW +: DW]),
      .hit_o   (chanHit[c])
    );
  end

  assign anyHit  = |chanHit;
  assign recPass = filter_pass(filter_mode_i, anyHit);

  always_comb begin
    payloadByte = 8'h00;
    for (int b = 0; b < NB; b++) begin
      if (idx_q == IW'(b)) payloadByte = rec_q[DW-1-8*b -: 8];
    end
  end

  // uart_tx lowers ready one cycle late, so the cycle after any strobe is never a send slot.
  assign sending = (state_q == ST_SYNC) || (state_q == ST_BYTE) || (state_q == ST_CSUM);
  assign txFire  = sending && bus.uart_ready && !block_q;

  always_comb begin
    case (state_q)
      ST_SYNC: txByte = SYNC;
      ST_BYTE: txByte = payloadByte;
      ST_CSUM: txByte = csum_q;
      default: txByte = 8'h00;
    endcase
  end

  assign bus.uart_clock_enable = txFire;
  assign bus.uart_data         = txByte;
  assign bus.read_clock_enable = (state_q == ST_POP);
  assign match_hit_o           = (state_q == ST_EVAL) && anyHit;
  assign filtered_count_o      = filtered_q;
  assign frame_count_o         = frames_q;

  always_comb begin
    state_d    = state_q;
    rec_d      = rec_q;
    idx_d      = idx_q;
    csum_d     = csum_q;
    filtered_d = filtered_q;
    frames_d   = frames_q;
    case (state_q)
      ST_IDLE: if (!bus.read_empty) state_d = ST_POP;
      ST_POP:  state_d = ST_WAIT;
      ST_WAIT: state_d = ST_EVAL;
      ST_EVAL: begin
        rec_d  = bus.read_data;
        csum_d = 8'h00;
        idx_d  = '0;
        if (recPass) begin
          state_d = ST_SYNC;
        end else begin
          if (filtered_q != '1) filtered_d = filtered_q + 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_SYNC: if (txFire) state_d = ST_BYTE;
      ST_BYTE: begin
        if (txFire) begin
          csum_d = csum_q ^ payloadByte;
          if (idx_q == LAST_IDX) state_d = ST_CSUM;
          else                   idx_d   = idx_q + 1'b1;
        end
      end
      ST_CSUM: begin
        if (txFire) begin
          frames_d = frames_q + 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      rec_q      <= '0;
      idx_q      <= '0;
      csum_q     <= 8'h00;
      block_q    <= 1'b0;
      filtered_q <= '0;
      frames_q   <= '0;
    end else begin
      state_q    <= state_d;
      rec_q      <= rec_d;
      idx_q      <= idx_d;
      csum_q     <= csum_d;
      block_q    <= txFire;
      filtered_q <= filtered_d;
      frames_q   <= frames_d;
    end
  end

endmodule

// File: tb/tb_lpc_record_framer.sv
// Scoreboard bench for lpc_record_framer: ringbuffer and uart_tx models, directed records.
module tb_lpc_record_framer;

  localparam int DW  = 48;
  localparam int NCH = 2;
  localparam int CW  = 16;

  localparam logic [DW-1:0] REC_A = 48'h0000_0080_3402;
  localparam logic [DW-1:0] REC_B = 48'h0000_03F9_1155;

  logic clock = 1'b0;
  logic reset = 1'b0;

  always #5 clock = ~clock;

  lpc_record_framer_if #(.DW(DW)) bus();

  logic [1:0]        filterMode;
  logic [NCH*DW-1:0] matchValue;
  logic [NCH*DW-1:0] matchMask;
  logic              matchHit;
  logic [CW-1:0]     filteredCount;
  logic [CW-1:0]     frameCount;
  logic [DW-1:0]     rdData = '0;

  assign bus.read_data = rdData;

  lpc_record_framer #(.DW(DW), .NCH(NCH), .SYNC(8'hA5), .CW(CW)) dut (
    .clock            (clock),
    .reset            (reset),
    .bus              (bus),
    .filter_mode_i    (filterMode),
    .match_value_i    (matchValue),
    .match_mask_i     (matchMask),
    .match_hit_o      (matchHit),
    .filtered_count_o (filteredCount),
    .frame_count_o    (frameCount)
  );

  logic [DW-1:0] rbq[$];
  logic [7:0]    expQ[$];
  int            checks = 0;
  int            failures = 0;
  int            popCount = 0;
  int            hitCount = 0;
  int            strobeCount = 0;
  int            stallCycles = 0;
  int            stallAt = 0;
  bit            stallArmed = 1'b0;
  bit            randomStall = 1'b0;
  bit            lastStrobe = 1'b0;
  logic [2:0]    strobeHist;
  logic [7:0]    expByte;
  bit            randBit;

  // Ringbuffer model: data appears the cycle after the pop strobe and stays until the next pop.
  always @(posedge clock) begin
    if (reset && bus.read_clock_enable) begin
      checks++;
      if (rbq.size() != 0) begin
        rdData <= rbq.pop_front();
      end else begin
        failures++;
        $display("[TB] FAIL pop_on_empty actual=pop required=no_pop");
      end
    end
  end

  // uart_tx model: ready stays high one cycle after a strobe, then drops for two cycles.
  initial begin
    bus.read_empty = 1'b1;
    bus.uart_ready = 1'b0;
    strobeHist     = '0;
    forever begin
      @(posedge clock);
      #1;
      strobeHist = {strobeHist[1:0], lastStrobe};
      if (!reset) strobeHist = '0;
      randBit = randomStall && ($urandom_range(0, 3) == 0);
      bus.uart_ready = (stallCycles == 0) && !randBit && !strobeHist[1] && !strobeHist[2];
      if (stallCycles > 0) stallCycles--;
      bus.read_empty = (rbq.size() == 0);
    end
  end

  // Monitor: pops expected bytes whenever the DUT strobes a byte out.
  always @(negedge clock) begin
    if (!reset) begin
      lastStrobe = 1'b0;
    end else begin
      if (bus.read_clock_enable) popCount++;
      if (matchHit) hitCount++;
      if (bus.uart_clock_enable) begin
        strobeCount++;
        checks++;
        if (!bus.uart_ready || lastStrobe) begin
          failures++;
          $display("[TB] FAIL uart_handshake actual ready=%0b prev_strobe=%0b required ready=1 prev_strobe=0",
                   bus.uart_ready, lastStrobe);
        end
        checks++;
        if (expQ.size() == 0) begin
          failures++;
          $display("[TB] FAIL unexpected_byte actual=%02h required=none", bus.uart_data);
        end else begin
          expByte = expQ.pop_front();
          if (bus.uart_data !== expByte) begin
            failures++;
            $display("[TB] FAIL uart_byte actual=%02h required=%02h", bus.uart_data, expByte);
          end
        end
        if (stallArmed && strobeCount == stallAt) begin
          stallCycles = 50;
          stallArmed  = 1'b0;
        end
      end
      lastStrobe = bus.uart_clock_enable;
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [DW-1:0] rec, input bit expectFrame, input logic [7:0] csum);
    if (expectFrame) begin
      expQ.push_back(8'hA5);
      for (int b = 0; b < DW / 8; b++) expQ.push_back(rec[DW-1-8*b -: 8]);
      expQ.push_back(csum);
    end
    rbq.push_back(rec);
  endtask

  task automatic waitDrain(input string name);
    int n;
    n = 0;
    while ((expQ.size() != 0 || rbq.size() != 0) && n < 5000) begin
      @(posedge clock);
      n++;
    end
    checks++;
    if (n >= 5000) begin
      failures++;
      $display("[TB] FAIL %s actual=timeout pending=%0d required=drained", name, expQ.size());
      expQ.delete();
      rbq.delete();
    end
    repeat (12) @(posedge clock);
    #1;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int pb, sb, hb, n;
    filterMode = 2'b00;
    matchValue = '0;
    matchMask  = '0;
    repeat (3) @(posedge clock);
    #2;
    checkOutput("reset_uart_ce",   64'(bus.uart_clock_enable), 64'd0);
    checkOutput("reset_read_ce",   64'(bus.read_clock_enable), 64'd0);
    checkOutput("reset_uart_data", 64'(bus.uart_data),         64'd0);
    checkOutput("reset_match_hit", 64'(matchHit),              64'd0);
    checkOutput("reset_filtered",  64'(filteredCount),         64'd0);
    checkOutput("reset_frames",    64'(frameCount),            64'd0);
    @(negedge clock);
    reset = 1'b1;

    pb = popCount; sb = strobeCount;
    applyStimulus(REC_A, 1'b1, 8'hB6);
    waitDrain("t1_drain");
    checkOutput("t1_pops",    64'(popCount - pb),    64'd1);
    checkOutput("t1_strobes", 64'(strobeCount - sb), 64'd8);
    checkOutput("t1_frames",  64'(frameCount),       64'd1);

    filterMode = 2'b01;
    matchValue = {REC_B, 48'h0000_0080_0000};
    matchMask  = {48'h0, 48'hFFFF_FFFF_0000};
    pb = popCount; hb = hitCount;
    applyStimulus(REC_A, 1'b1, 8'hB6);
    applyStimulus(REC_B, 1'b0, 8'h00);
    waitDrain("t2_drain");
    checkOutput("t2_pops",     64'(popCount - pb), 64'd2);
    checkOutput("t2_hits",     64'(hitCount - hb), 64'd1);
    checkOutput("t2_filtered", 64'(filteredCount), 64'd1);
    checkOutput("t2_frames",   64'(frameCount),    64'd2);

    filterMode = 2'b10;
    hb = hitCount;
    applyStimulus(REC_A, 1'b0, 8'h00);
    applyStimulus(REC_B, 1'b1, 8'hBE);
    waitDrain("t3_drain");
    checkOutput("t3_hits",     64'(hitCount - hb), 64'd1);
    checkOutput("t3_filtered", 64'(filteredCount), 64'd2);
    checkOutput("t3_frames",   64'(frameCount),    64'd3);

    filterMode  = 2'b00;
    randomStall = 1'b1;
    pb = popCount; sb = strobeCount;
    stallAt    = strobeCount + 3;
    stallArmed = 1'b1;
    applyStimulus(REC_A, 1'b1, 8'hB6);
    waitDrain("t4_drain");
    randomStall = 1'b0;
    checkOutput("t4_pops",        64'(popCount - pb),    64'd1);
    checkOutput("t4_strobes",     64'(strobeCount - sb), 64'd8);
    checkOutput("t4_stall_fired", 64'(stallArmed),       64'd0);
    checkOutput("t4_frames",      64'(frameCount),       64'd4);

    pb = popCount; sb = strobeCount;
    applyStimulus(48'h1122_3344_5566, 1'b1, 8'h77);
    applyStimulus(48'hFFFF_FFFF_FFFF, 1'b1, 8'h00);
    applyStimulus(48'h0102_0408_1020, 1'b1, 8'h3F);
    applyStimulus(48'hA5A5_0000_5A5A, 1'b1, 8'h00);
    waitDrain("t5_drain");
    checkOutput("t5_pops",    64'(popCount - pb),    64'd4);
    checkOutput("t5_strobes", 64'(strobeCount - sb), 64'd32);
    checkOutput("t5_frames",  64'(frameCount),       64'd8);

    filterMode = 2'b11;
    hb = hitCount;
    applyStimulus(REC_A, 1'b1, 8'hB6);
    waitDrain("t5b_drain");
    checkOutput("t5b_hits",   64'(hitCount - hb), 64'd1);
    checkOutput("t5b_frames", 64'(frameCount),    64'd9);

    filterMode = 2'b00;
    sb = strobeCount;
    applyStimulus(REC_A, 1'b1, 8'hB6);
    n = 0;
    while (strobeCount < sb + 3 && n < 2000) begin
      @(posedge clock);
      n++;
    end
    checkOutput("t6_reach_byte2", 64'(n < 2000), 64'd1);
    @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("t6_uart_ce",   64'(bus.uart_clock_enable), 64'd0);
    checkOutput("t6_read_ce",   64'(bus.read_clock_enable), 64'd0);
    checkOutput("t6_uart_data", 64'(bus.uart_data),         64'd0);
    checkOutput("t6_frames",    64'(frameCount),            64'd0);
    checkOutput("t6_filtered",  64'(filteredCount),         64'd0);
    expQ.delete();
    rbq.delete();
    repeat (2) @(negedge clock);
    reset = 1'b1;
    pb = popCount;
    applyStimulus(48'h1122_3344_5566, 1'b1, 8'h77);
    waitDrain("t6_drain");
    checkOutput("t6_pops_after",   64'(popCount - pb), 64'd1);
    checkOutput("t6_frames_after", 64'(frameCount),    64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
